// File: rtl/result_capture_fifo_pkg.sv
// Package: result_capture_pkg
// Purpose: shared sizing constants and helpers for the result capture FIFO.
//   RC_WIDTH  - width of captured results
//   RC_DEPTH  - number of FIFO entries (power of two, >= 2)
//   RC_DROP_W - width of the saturating drop counter
//   ptr_w()   - FIFO pointer width for a given depth
package result_capture_pkg;

  localparam int RC_WIDTH  = 12;
  localparam int RC_DEPTH  = 8;
  localparam int RC_DROP_W = 8;

  // Pointer width for a power-of-two depth; pointers wrap naturally.
  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/result_capture_fifo_sync_fifo.sv
// Module: sync_fifo
// Purpose: single-clock first-word-fall-through FIFO with async active-high reset.
// Ports:
//   clk, rst          - clock and asynchronous active-high reset
//   push_i, data_i    - write request and write data (ignored when full without a pop)
//   pop_i             - read request (ignored when empty)
//   head_o            - current head entry (valid when empty_o is low)
//   full_o, empty_o   - occupancy flags
//   count_o           - number of entries held, 0..DEPTH
module sync_fifo
  import result_capture_pkg::*;
#(
  parameter int WIDTH = RC_WIDTH,
  parameter int DEPTH = RC_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           head_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [ptr_w(DEPTH):0]      count_o
);

  localparam int PW = ptr_w(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             wr_en_s, rd_en_s;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == {CW{1'b0}});
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // A pop in the same cycle frees the head slot, so a full FIFO may still accept a push.
  assign wr_en_s = push_i & (~full_o | pop_i);
  assign rd_en_s = pop_i & ~empty_o;

  // Next-state pointers and occupancy.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en_s) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (rd_en_s) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({wr_en_s, rd_en_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage and pointer registers; storage is cleared so the head reads zero after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      count_q  <= {CW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (wr_en_s) begin
        mem_q[wr_ptr_q] <= data_i;
      end
    end
  end

endmodule

// File: rtl/result_capture_fifo.sv
// Module: result_capture_fifo
// Purpose: captures result y on each rising edge of the asynchronous enable e,
//   buffers samples in a FIFO and drains them over valid/ready; counts drops.
// Ports:
//   clk, rst              - clock and asynchronous active-high reset
//   e                     - asynchronous capture enable (rising edge captures)
//   y                     - result to capture
//   out_data, out_valid   - FIFO head (first-word fall-through) and its valid
//   out_ready             - consumer accepts the head this cycle
//   count                 - entries held, 0..DEPTH
//   overflow              - sticky flag: a sample was dropped since reset
//   drop_cnt              - saturating count of dropped samples
module result_capture_fifo
  import result_capture_pkg::*;
#(
  parameter int WIDTH       = RC_WIDTH,
  parameter int DEPTH       = RC_DEPTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    e,
  input  logic [WIDTH-1:0]        y,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    overflow,
  output logic [RC_DROP_W-1:0]    drop_cnt
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic                   overflow_q, overflow_d;
  logic [RC_DROP_W-1:0]   drop_cnt_q, drop_cnt_d;
  logic                   es_s, cap_s, pop_s, drop_s;
  logic                   full_s, empty_s;

  assign es_s      = sync_q[SYNC_STAGES-1];
  assign cap_s     = es_s & ~prev_q;
  assign out_valid = ~empty_s;
  assign pop_s     = out_valid & out_ready;
  // A full FIFO only drops when no pop frees a slot in the same cycle.
  assign drop_s    = cap_s & full_s & ~pop_s;
  assign overflow  = overflow_q;
  assign drop_cnt  = drop_cnt_q;

  // Synchroniser shift, edge-detect history and drop bookkeeping.
  always_comb begin
    sync_d     = {sync_q[SYNC_STAGES-2:0], e};
    prev_d     = es_s;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (drop_s) begin
      overflow_d = 1'b1;
      if (drop_cnt_q != {RC_DROP_W{1'b1}}) begin
        drop_cnt_d = drop_cnt_q + RC_DROP_W'(1);
      end else begin
        drop_cnt_d = drop_cnt_q;
      end
    end else begin
      overflow_d = overflow_q;
      drop_cnt_d = drop_cnt_q;
    end
  end

  // Synchroniser and edge-detect flops reset high so a held-high e is not a capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q     <= {SYNC_STAGES{1'b1}};
      prev_q     <= 1'b1;
      overflow_q <= 1'b0;
      drop_cnt_q <= {RC_DROP_W{1'b0}};
    end else begin
      sync_q     <= sync_d;
      prev_q     <= prev_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (cap_s),
    .data_i  (y),
    .pop_i   (pop_s),
    .head_o  (out_data),
    .full_o  (full_s),
    .empty_o (empty_s),
    .count_o (count)
  );

endmodule

// File: tb/tb_result_capture_fifo.sv
// Testbench for result_capture_fifo: directed steps with hand-computed expectations.
module tb_result_capture_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic        e;
  logic [11:0] y;
  logic [11:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  count;
  logic        overflow;
  logic [7:0]  drop_cnt;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  result_capture_fifo dut (
    .clk       (clk),
    .rst       (rst),
    .e         (e),
    .y         (y),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count),
    .overflow  (overflow),
    .drop_cnt  (drop_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
  endtask

  // One e pulse: high for two cycles, low for two; the push lands on the third edge.
  task automatic capture(input logic [11:0] v);
    y = v;
    e = 1'b1;
    tick();
    tick();
    e = 1'b0;
    tick();
    tick();
  endtask

  logic [11:0] exp_q [$];

  initial begin
    rst = 1'b1;
    e = 1'b0;
    y = 12'h000;
    out_ready = 1'b0;
    tick();
    tick();
    check("rst_valid", out_valid, 0);
    check("rst_count", count, 0);
    check("rst_data", out_data, 0);
    check("rst_ovf", overflow, 0);
    check("rst_drop", drop_cnt, 0);
    rst = 1'b0;
    tick();
    tick();

    // 1: single capture with consumer ready
    out_ready = 1'b1;
    y = 12'hDFC;
    e = 1'b1;
    tick();
    check("t1_valid_k", out_valid, 0);
    tick();
    check("t1_valid_k1", out_valid, 0);
    tick();
    check("t1_valid_k2", out_valid, 1);
    check("t1_data", out_data, 12'hDFC);
    check("t1_count1", count, 1);
    e = 1'b0;
    tick();
    check("t1_valid_after", out_valid, 0);
    check("t1_count0", count, 0);
    tick();
    tick();

    // 2: burst into a stalled consumer, then one drop
    out_ready = 1'b0;
    for (int i = 1; i <= 8; i++) capture(12'(i));
    check("t2_count8", count, 8);
    check("t2_ovf0", overflow, 0);
    capture(12'h009);
    check("t2_drop1", drop_cnt, 1);
    check("t2_ovf1", overflow, 1);
    check("t2_count_hold", count, 8);
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      check("t2_drain_valid", out_valid, 1);
      check("t2_drain_data", out_data, i);
      tick();
    end
    check("t2_empty", out_valid, 0);
    check("t2_count_end", count, 0);
    out_ready = 1'b0;

    // 3: push into a full FIFO while popping
    for (int i = 1; i <= 8; i++) capture(12'h0A0 + 12'(i));
    check("t3_full", count, 8);
    y = 12'h0E7;
    e = 1'b1;
    tick();
    tick();
    out_ready = 1'b1;
    e = 1'b0;
    tick();
    out_ready = 1'b0;
    check("t3_count", count, 8);
    check("t3_nodrop", drop_cnt, 1);
    check("t3_head", out_data, 12'h0A2);
    tick();
    tick();
    for (int i = 2; i <= 8; i++) exp_q.push_back(12'h0A0 + 12'(i));
    exp_q.push_back(12'h0E7);
    out_ready = 1'b1;
    while (exp_q.size() > 0) begin
      check("t3_drain", out_data, exp_q.pop_front());
      tick();
    end
    check("t3_count_end", count, 0);
    out_ready = 1'b0;

    // 4: backpressure pattern 1,0,0,1
    capture(12'h5B4);
    capture(12'hDFC);
    check("t4_count", count, 2);
    check("t4_hold0", out_data, 12'h5B4);
    tick();
    check("t4_hold1", out_data, 12'h5B4);
    out_ready = 1'b1;
    check("t4_pop_a", out_data, 12'h5B4);
    tick();
    out_ready = 1'b0;
    check("t4_stall_b", out_data, 12'hDFC);
    check("t4_count_b", count, 1);
    tick();
    check("t4_stall_c", out_data, 12'hDFC);
    out_ready = 1'b1;
    check("t4_pop_d", out_data, 12'hDFC);
    tick();
    out_ready = 1'b0;
    check("t4_empty", out_valid, 0);
    check("t4_count_end", count, 0);

    // 5a: e held high through reset release is not a capture
    rst = 1'b1;
    e = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("t5_nocap_valid", out_valid, 0);
    check("t5_nocap_count", count, 0);
    check("t5_ovf_clr", overflow, 0);
    check("t5_drop_clr", drop_cnt, 0);
    e = 1'b0;
    tick();
    tick();
    tick();

    // 5b: reset mid-burst clears outputs immediately
    for (int i = 0; i < 5; i++) capture(12'h300 + 12'(i));
    check("t5_count5", count, 5);
    rst = 1'b1;
    #1;
    check("t5_rst_count", count, 0);
    check("t5_rst_valid", out_valid, 0);
    check("t5_rst_data", out_data, 0);
    check("t5_rst_drop", drop_cnt, 0);
    tick();
    rst = 1'b0;
    tick();
    tick();

    // 6: drop counter saturation
    for (int i = 0; i < 262; i++) capture(12'(i));
    check("t6_drop254", drop_cnt, 254);
    for (int i = 0; i < 38; i++) capture(12'(i));
    check("t6_drop255", drop_cnt, 255);
    check("t6_ovf", overflow, 1);
    check("t6_count", count, 8);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
